uart_boot_loader: RTL

Boot-time program loader sitting between the UART rx/tx FIFOs, the instruction memory write port and the core's reset. Holds the core in reset, receives a length-prefixed little-endian program image over UART, and writes it word by word into imem starting at word address 0. Acknowledges the load over UART tx, then releases the core. Reports a malformed length as an error and keeps the core in reset.

---
 rtl/uart_boot_loader.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// Boot loader: holds the core in reset, pulls a length-prefixed little-endian
// image from the UART rx FIFO into imem from word 0, then ACKs and releases the core.
module uart_boot_loader #(
  parameter int unsigned ADDR_W   = 10,
  parameter logic [7:0]  ACK_BYTE = 8'hAA,
  parameter logic [7:0]  ERR_BYTE = 8'hEE
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        uart_rx_data,
  input  logic              empty,
  output logic              uart_rd_en,
  output logic [7:0]        uart_tx_data,
  input  logic              full,
  output logic              uart_wr_en,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn,
  output logic              done,
  output logic              error
);

  localparam logic [31:0] MAX_N = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_ACK,
    S_RUN,
    S_ERR,
    S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [1:0]          r_bc;
  logic [31:0]         r_shift;
  logic [ADDR_W:0]     r_n;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [31:0]         r_wdata;
  logic                r_cpu_rstn;
  logic                r_done;
  logic                r_error;

  logic                w_pop;
  logic                w_push;
  logic [7:0]          w_tx_data;
  logic [31:0]         w_word;
  logic                w_word_done;
  logic                w_len_bad;
  logic [ADDR_W:0]     w_idx_inc;
  logic                w_last;

  // Current byte merged into the shift register; complete word when bc==3.
  always_comb begin
    w_word = r_shift;
    w_word[{r_bc, 3'b000} +: 8] = uart_rx_data;
  end

  assign w_word_done = w_pop & (r_bc == 2'd3);
  assign w_len_bad   = (w_word == '0) | (w_word > MAX_N);
  assign w_idx_inc   = {1'b0, r_idx} + {{ADDR_W{1'b0}}, 1'b1};
  assign w_last      = (w_idx_inc == r_n);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_LEN;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LEN: begin
        if (w_word_done) begin
          w_next = w_len_bad ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        if (w_word_done && w_last) begin
          w_next = S_ACK;
        end
      end
      S_ACK: begin
        if (!full) begin
          w_next = S_RUN;
        end
      end
      S_RUN:   w_next = S_RUN;
      S_ERR: begin
        if (!full) begin
          w_next = S_HALT;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_LEN;
    endcase
  end

  always_comb begin
    w_pop     = 1'b0;
    w_push    = 1'b0;
    w_tx_data = ACK_BYTE;
    case (r_state)
      S_LEN, S_DATA: w_pop = rstn & ~empty;
      S_ACK: begin
        w_push    = ~full;
        w_tx_data = ACK_BYTE;
      end
      S_ERR: begin
        w_push    = ~full;
        w_tx_data = ERR_BYTE;
      end
      S_HALT:  w_tx_data = ERR_BYTE;
      default: w_tx_data = ACK_BYTE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_bc       <= '0;
      r_shift    <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_cpu_rstn <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_pop) begin
        r_shift <= w_word;
        r_bc    <= r_bc + 2'd1;
      end
      if (r_state == S_LEN && w_word_done && !w_len_bad) begin
        r_n   <= w_word[ADDR_W:0];
        r_idx <= '0;
      end
      if (r_state == S_DATA && w_word_done) begin
        r_we    <= 1'b1;
        r_wdata <= w_word;
        r_waddr <= r_idx;
        r_idx   <= w_idx_inc[ADDR_W-1:0];
      end
      // Status flags follow the state being entered so they rise with it.
      r_cpu_rstn <= (w_next == S_RUN);
      r_done     <= (w_next == S_RUN);
      r_error    <= (w_next == S_ERR) | (w_next == S_HALT);
    end
  end

  assign uart_rd_en   = w_pop;
  assign uart_wr_en   = w_push;
  assign uart_tx_data = w_tx_data;
  assign imem_we      = r_we;
  assign imem_waddr   = r_waddr;
  assign imem_wdata   = r_wdata;
  assign cpu_rstn     = r_cpu_rstn;
  assign done         = r_done;
  assign error        = r_error;

endmodule
